// File: rtl/exe_stage.sv
// ARM execute stage: operand forwarding, Val2 generation, ALU, branch target and NZCV register.
// Optional FORWARDING_EN routes sel_src_1/sel_src_2 through the forward muxes.
module exe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             imm_in,
    input  logic             s_in,
    input  logic             b_in,
    input  logic             MEM_r_en_in,
    input  logic             MEM_w_en_in,
    input  logic             WB_enable_in,
    input  logic [3:0]       exec_cmd_in,
    input  logic [3:0]       dest_in,
    input  logic [11:0]      shift_operand_in,
    input  logic [23:0]      signed_immed_24_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] val_rn_in,
    input  logic [WIDTH-1:0] val_rm_in,
    input  logic [1:0]       sel_src_1,
    input  logic [1:0]       sel_src_2,
    input  logic [WIDTH-1:0] mem_fwd_val,
    input  logic [WIDTH-1:0] wb_fwd_val,
    output logic [3:0]       status_out,
    output logic             branch_taken,
    output logic [WIDTH-1:0] branch_addr,
    output logic             WB_enable_out,
    output logic             MEM_r_en_out,
    output logic             MEM_w_en_out,
    output logic [WIDTH-1:0] alu_res_out,
    output logic [WIDTH-1:0] val_rm_out,
    output logic [3:0]       dest_out
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic [3:0]       status_q, status_d;
    logic [WIDTH-1:0] alu_res_q, alu_res_d;
    logic [WIDTH-1:0] val_rm_q, val_rm_d;
    logic [3:0]       dest_q, dest_d;
    logic             wb_en_q, wb_en_d;
    logic             mem_r_q, mem_r_d;
    logic             mem_w_q, mem_w_d;

    logic [WIDTH-1:0] op_a, op_rm, val2, res;
    logic [2*WIDTH-1:0] rot_dbl;
    logic [4:0]       rot_amt, sh_amt;
    logic [3:0]       cmd;
    logic [WIDTH:0]   sum;
    logic             mem_op, cin, flag_c, flag_v;

    always_comb begin
`ifdef FORWARDING_EN
        case (sel_src_1)
            2'b01:   op_a = mem_fwd_val;
            2'b10:   op_a = wb_fwd_val;
            default: op_a = val_rn_in;
        endcase
        case (sel_src_2)
            2'b01:   op_rm = mem_fwd_val;
            2'b10:   op_rm = wb_fwd_val;
            default: op_rm = val_rm_in;
        endcase
`else
        op_a  = val_rn_in;
        op_rm = val_rm_in;
`endif
    end

    assign mem_op = MEM_r_en_in | MEM_w_en_in;

    // Val2: rotations use a doubled word so a zero amount needs no special case.
    always_comb begin
        rot_amt = {shift_operand_in[11:8], 1'b0};
        sh_amt  = shift_operand_in[11:7];
        rot_dbl = '0;
        val2    = op_rm;
        if (mem_op) begin
            val2 = {{(WIDTH-12){1'b0}}, shift_operand_in};
        end else if (imm_in) begin
            rot_dbl = {{(WIDTH-8){1'b0}}, shift_operand_in[7:0],
                       {(WIDTH-8){1'b0}}, shift_operand_in[7:0]} >> rot_amt;
            val2    = rot_dbl[WIDTH-1:0];
        end else begin
            case (shift_operand_in[6:5])
                2'b00: val2 = op_rm << sh_amt;
                2'b01: val2 = op_rm >> sh_amt;
                2'b10: val2 = WIDTH'($signed(op_rm) >>> sh_amt);
                default: begin
                    rot_dbl = {op_rm, op_rm} >> sh_amt;
                    val2    = rot_dbl[WIDTH-1:0];
                end
            endcase
        end
    end

    // Subtraction is A + ~B + carry so C falls out as NOT borrow.
    always_comb begin
        cmd    = mem_op ? CMD_ADD : exec_cmd_in;
        cin    = status_q[1];
        sum    = '0;
        res    = '0;
        flag_c = status_q[1];
        flag_v = status_q[0];
        case (cmd)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_AND: res = op_a & val2;
            CMD_ORR: res = op_a | val2;
            CMD_EOR: res = op_a ^ val2;
            CMD_ADD, CMD_ADC: begin
                sum    = {1'b0, op_a} + {1'b0, val2}
                       + {{WIDTH{1'b0}}, (cmd == CMD_ADC) & cin};
                res    = sum[WIDTH-1:0];
                flag_c = sum[WIDTH];
                flag_v = (op_a[WIDTH-1] == val2[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                sum    = {1'b0, op_a} + {1'b0, ~val2}
                       + {{WIDTH{1'b0}}, (cmd == CMD_SUB) | cin};
                res    = sum[WIDTH-1:0];
                flag_c = sum[WIDTH];
                flag_v = (op_a[WIDTH-1] != val2[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
            end
            default: res = '0;
        endcase
    end

    always_comb begin
        status_d  = status_q;
        alu_res_d = alu_res_q;
        val_rm_d  = val_rm_q;
        dest_d    = dest_q;
        wb_en_d   = wb_en_q;
        mem_r_d   = mem_r_q;
        mem_w_d   = mem_w_q;
        if (!stall) begin
            alu_res_d = res;
            val_rm_d  = op_rm;
            dest_d    = dest_in;
            wb_en_d   = WB_enable_in;
            mem_r_d   = MEM_r_en_in;
            mem_w_d   = MEM_w_en_in;
            if (s_in)
                status_d = {res[WIDTH-1], res == '0, flag_c, flag_v};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= '0;
            alu_res_q <= '0;
            val_rm_q  <= '0;
            dest_q    <= '0;
            wb_en_q   <= 1'b0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
        end else begin
            status_q  <= status_d;
            alu_res_q <= alu_res_d;
            val_rm_q  <= val_rm_d;
            dest_q    <= dest_d;
            wb_en_q   <= wb_en_d;
            mem_r_q   <= mem_r_d;
            mem_w_q   <= mem_w_d;
        end
    end

    assign branch_taken  = b_in;
    assign branch_addr   = pc_in + {{(WIDTH-26){signed_immed_24_in[23]}}, signed_immed_24_in, 2'b00};
    assign status_out    = status_q;
    assign alu_res_out   = alu_res_q;
    assign val_rm_out    = val_rm_q;
    assign dest_out      = dest_q;
    assign WB_enable_out = wb_en_q;
    assign MEM_r_en_out  = mem_r_q;
    assign MEM_w_en_out  = mem_w_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage; FORWARDING_EN selects which forwarding vectors apply.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst, stall, imm_in, s_in, b_in, MEM_r_en_in, MEM_w_en_in, WB_enable_in;
    logic [3:0]  exec_cmd_in, dest_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_immed_24_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in, mem_fwd_val, wb_fwd_val;
    logic [1:0]  sel_src_1, sel_src_2;
    logic [3:0]  status_out, dest_out;
    logic        branch_taken, WB_enable_out, MEM_r_en_out, MEM_w_en_out;
    logic [31:0] branch_addr, alu_res_out, val_rm_out;

    int checks = 0;
    int failures = 0;

    exe_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .imm_in(imm_in), .s_in(s_in), .b_in(b_in),
        .MEM_r_en_in(MEM_r_en_in), .MEM_w_en_in(MEM_w_en_in), .WB_enable_in(WB_enable_in),
        .exec_cmd_in(exec_cmd_in), .dest_in(dest_in), .shift_operand_in(shift_operand_in),
        .signed_immed_24_in(signed_immed_24_in), .pc_in(pc_in), .val_rn_in(val_rn_in),
        .val_rm_in(val_rm_in), .sel_src_1(sel_src_1), .sel_src_2(sel_src_2),
        .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val), .status_out(status_out),
        .branch_taken(branch_taken), .branch_addr(branch_addr), .WB_enable_out(WB_enable_out),
        .MEM_r_en_out(MEM_r_en_out), .MEM_w_en_out(MEM_w_en_out), .alu_res_out(alu_res_out),
        .val_rm_out(val_rm_out), .dest_out(dest_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; imm_in = 0; s_in = 0; b_in = 0;
        MEM_r_en_in = 0; MEM_w_en_in = 0; WB_enable_in = 0;
        exec_cmd_in = 4'b0000; dest_in = 4'd0; shift_operand_in = 12'h000;
        signed_immed_24_in = 24'h0; pc_in = 32'h0; val_rn_in = 32'h0; val_rm_in = 32'h0;
        sel_src_1 = 2'b00; sel_src_2 = 2'b00; mem_fwd_val = 32'h0; wb_fwd_val = 32'h0;
    endtask

    // Shift/logic table: {cmd, imm, so, rn, rm, expected result}
    typedef struct {
        string       tag;
        logic [3:0]  cmd;
        logic        imm;
        logic [11:0] so;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        idle();
        rst = 1;
        step();
        chk("rst_res", alu_res_out, 32'h0);
        chk("rst_status", {28'h0, status_out}, 32'h0);
        chk("rst_ctrl", {28'h0, WB_enable_out, MEM_r_en_out, MEM_w_en_out, 1'b0}, 32'h0);
        rst = 0;

        // ADD imm 0xFF + 1, flags untouched
        exec_cmd_in = 4'b0010; imm_in = 1; shift_operand_in = 12'h0FF; val_rn_in = 32'd1;
        WB_enable_in = 1; dest_in = 4'd3;
        step();
        chk("add_imm", alu_res_out, 32'h100);
        chk("add_nos_status", {28'h0, status_out}, 32'h0);
        chk("add_dest", {27'h0, WB_enable_out, dest_out}, 32'h13);

        // SUB 5-5 -> Z,C
        idle(); exec_cmd_in = 4'b0100; s_in = 1; val_rn_in = 32'd5; val_rm_in = 32'd5;
        step();
        chk("sub_zero", alu_res_out, 32'h0);
        chk("sub_status", {28'h0, status_out}, 32'h6);

        // ADC with registered C=1: 1 + (2 ror 8) + 1
        idle(); exec_cmd_in = 4'b0011; imm_in = 1; shift_operand_in = 12'h402; val_rn_in = 32'd1;
        step();
        chk("adc_cin", alu_res_out, 32'h02000002);
        chk("adc_status_hold", {28'h0, status_out}, 32'h6);

        // Signed overflow
        idle(); exec_cmd_in = 4'b0010; s_in = 1; imm_in = 1; shift_operand_in = 12'h001;
        val_rn_in = 32'h7FFFFFFF;
        step();
        chk("add_ovf", alu_res_out, 32'h80000000);
        chk("add_ovf_status", {28'h0, status_out}, 32'h9);

        // SBC with C=0: 10 - 3 - 1 = 6, no borrow
        idle(); exec_cmd_in = 4'b0101; s_in = 1; imm_in = 1; shift_operand_in = 12'h003;
        val_rn_in = 32'd10;
        step();
        chk("sbc", alu_res_out, 32'd6);
        chk("sbc_status", {28'h0, status_out}, 32'h2);

        // SUB with borrow: 1 - 2
        idle(); exec_cmd_in = 4'b0100; s_in = 1; imm_in = 1; shift_operand_in = 12'h002;
        val_rn_in = 32'd1;
        step();
        chk("sub_borrow", alu_res_out, 32'hFFFFFFFF);
        chk("sub_borrow_status", {28'h0, status_out}, 32'h8);

        // Logic op with S: N,Z update, C,V kept (C=0,V=0 here) -> Z only
        idle(); exec_cmd_in = 4'b0110; s_in = 1; imm_in = 1; shift_operand_in = 12'h00F;
        val_rn_in = 32'hF0;
        step();
        chk("and_zero", alu_res_out, 32'h0);
        chk("and_status", {28'h0, status_out}, 32'h4);

        vecs.push_back('{"mov_lsl1", 4'b0001, 1'b0, 12'h080, 32'h0, 32'h00000001, 32'h00000002});
        vecs.push_back('{"mov_lsr4", 4'b0001, 1'b0, 12'h220, 32'h0, 32'h80000001, 32'h08000000});
        vecs.push_back('{"mov_asr4", 4'b0001, 1'b0, 12'h240, 32'h0, 32'h80000001, 32'hF8000000});
        vecs.push_back('{"mov_ror4", 4'b0001, 1'b0, 12'h260, 32'h0, 32'h80000001, 32'h18000000});
        vecs.push_back('{"mov_asr0", 4'b0001, 1'b0, 12'h040, 32'h0, 32'h80000001, 32'h80000001});
        vecs.push_back('{"mvn_imm0", 4'b1001, 1'b1, 12'h000, 32'h0, 32'h0, 32'hFFFFFFFF});
        vecs.push_back('{"and_imm", 4'b0110, 1'b1, 12'h0FF, 32'hF0F0, 32'h0, 32'h000000F0});
        vecs.push_back('{"orr_imm", 4'b0111, 1'b1, 12'h0FF, 32'hF0F0, 32'h0, 32'h0000F0FF});
        vecs.push_back('{"eor_imm", 4'b1000, 1'b1, 12'h0FF, 32'hF0F0, 32'h0, 32'h0000F00F});
        vecs.push_back('{"rot_imm", 4'b0001, 1'b1, 12'hF81, 32'h0, 32'h0, 32'h00000204});
        vecs.push_back('{"undef_cmd", 4'b0000, 1'b1, 12'h0FF, 32'h5, 32'h0, 32'h0});
        foreach (vecs[i]) begin
            idle();
            exec_cmd_in = vecs[i].cmd; imm_in = vecs[i].imm; shift_operand_in = vecs[i].so;
            val_rn_in = vecs[i].rn; val_rm_in = vecs[i].rm;
            step();
            chk(vecs[i].tag, alu_res_out, vecs[i].exp);
        end
        chk("status_kept", {28'h0, status_out}, 32'h4);

        // Load: forced ADD, zero-extended offset even with imm_in set
        idle(); MEM_r_en_in = 1; WB_enable_in = 1; exec_cmd_in = 4'b0110; imm_in = 1;
        shift_operand_in = 12'h004; val_rn_in = 32'h100; val_rm_in = 32'hDEADBEEF; dest_in = 4'd9;
        step();
        chk("ldr_addr", alu_res_out, 32'h104);
        chk("ldr_ctrl", {26'h0, WB_enable_out, MEM_r_en_out, MEM_w_en_out, 3'b0}, 32'h30);
        chk("ldr_rm", val_rm_out, 32'hDEADBEEF);

        idle(); stall = 1; s_in = 1; exec_cmd_in = 4'b0001; val_rm_in = 32'h55; MEM_w_en_in = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_res", alu_res_out, 32'h104);
            chk("stall_status", {24'h0, status_out, dest_out}, 32'h49);
        end
        rst = 1;
        step();
        chk("rst_stall_res", alu_res_out, 32'h0);
        chk("rst_stall_misc", {val_rm_out[27:0], status_out}, 32'h0);
        chk("rst_stall_ctrl", {26'h0, WB_enable_out, MEM_r_en_out, MEM_w_en_out, dest_out[2:0]}, 32'h0);
        rst = 0;

        // Combinational branch target
        idle(); b_in = 1; pc_in = 32'h20; signed_immed_24_in = 24'hFFFFFE;
        #1;
        chk("br_back", branch_addr, 32'h18);
        chk("br_taken", {31'h0, branch_taken}, 32'h1);
        pc_in = 32'h100; signed_immed_24_in = 24'h000010;
        #1;
        chk("br_fwd", branch_addr, 32'h140);

        idle(); exec_cmd_in = 4'b0010; imm_in = 1; shift_operand_in = 12'h001;
        val_rn_in = 32'd100; sel_src_1 = 2'b01; mem_fwd_val = 32'd7;
        step();
`ifdef FORWARDING_EN
        chk("fwd_mem_rn", alu_res_out, 32'd8);
`else
        chk("nofwd_rn", alu_res_out, 32'd101);
`endif
        idle(); exec_cmd_in = 4'b0001; val_rm_in = 32'd20; sel_src_2 = 2'b10; wb_fwd_val = 32'd3;
        step();
`ifdef FORWARDING_EN
        chk("fwd_wb_rm", alu_res_out, 32'd3);
        chk("fwd_wb_store", val_rm_out, 32'd3);
`else
        chk("nofwd_rm", alu_res_out, 32'd20);
        chk("nofwd_store", val_rm_out, 32'd20);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline, directly downstream of the ID/EXE pipeline register.
- Builds the second ALU operand (Val2) and executes the ALU command.
- Computes the branch target and owns the NZCV status register.
- Registers its results into the EXE/MEM boundary, so the MEM stage sees registered values.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- stall  in  1  memory-wait hold; freezes output register and status register
- imm_in  in  1  I bit
- s_in  in  1  S bit; update flags
- b_in  in  1  branch instruction
- MEM_r_en_in  in  1  load
- MEM_w_en_in  in  1  store
- WB_enable_in  in  1  writeback
- exec_cmd_in  in  4  ALU command
- dest_in  in  4  destination register
- shift_operand_in  in  12  shifter operand
- signed_immed_24_in  in  24  branch offset
- pc_in  in  32  PC+4 of instruction
- val_rn_in  in  32  Rn from register file
- val_rm_in  in  32  Rm from register file
- sel_src_1  in  2  Rn forward select (00 regfile, 01 MEM, 10 WB, 11 regfile)
- sel_src_2  in  2  Rm forward select, same encoding
- mem_fwd_val  in  32  ALU result currently in MEM
- wb_fwd_val  in  32  writeback value
- status_out  out  4  registered NZCV {N,Z,C,V}, to ID condition check
- branch_taken  out  1  combinational = b_in
- branch_addr  out  32  combinational pc_in + (sext(signed_immed_24_in) << 2)
- WB_enable_out  out  1  registered
- MEM_r_en_out  out  1  registered
- MEM_w_en_out  out  1  registered
- alu_res_out  out  32  registered ALU result / memory address
- val_rm_out  out  32  registered store data (post-forward Rm)
- dest_out  out  4  registered

Behaviour:
- Reset: on a rising clk with rst=1, every registered output is 0, including status_out. rst has priority over stall.
- Latency: inputs settle in cycle N; registered outputs are valid after the edge ending cycle N. branch_taken and branch_addr are combinational with no latency.
- stall=1: all registered outputs and the status register hold.
- Operand select: A = Rn after the forward mux. Rm' = Rm after the forward mux.
- Val2 priority:
  - MEM_r_en_in|MEM_w_en_in: zero-extended shift_operand_in[11:0].
  - Else imm_in=1: {24'b0, so[7:0]} rotated right by 2*so[11:8].
  - Else: Rm' shifted by so[11:7] using type so[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes Rm' through unchanged (no RRX).
- ALU (exec_cmd_in); Cin = status C:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: A+Val2
  - 0011 ADC: A+Val2+Cin
  - 0100 SUB: A-Val2
  - 0101 SBC: A-Val2-!Cin
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - Any other code: result 0.
- Memory operations force ADD, regardless of exec_cmd_in.
- Flags:
  - N = res[31]. Z = (res==0).
  - Add/sub: C and V are computed from a 33-bit result. C = carry out; for SUB/SBC, C = NOT borrow.
  - V = signed overflow.
  - Logic/move commands leave C and V unchanged.
- Status register writes at the edge iff s_in & !stall & !rst. With s_in=0 it holds.
- Back-to-back flag-setting instructions: the second one uses the C written by the first (registered value).
- Width: branch offset = {{6{imm24[23]}}, imm24, 2'b00}; wraps modulo 2^32. All arithmetic wraps modulo 2^32.

Optional Feature:
- FORWARDING_EN defined: sel_src_1 and sel_src_2 drive the forward muxes as specified.
- Undefined: sel inputs, mem_fwd_val and wb_fwd_val are ignored. A = val_rn_in and Rm' = val_rm_in. The hazard unit stalls instead of forwarding.

Test Plan:
- Reset, then ADD with imm=1, so=12'h0FF, Rn=1 -> alu_res_out=0x100 one cycle later; status stays 0 with s_in=0.
- SUB, s_in=1, Rn=5, shift-mode Val2=Rm=5 (so[11:0]=0) -> res=0; status_out=4'b0110 (Z,C) next edge.
- ADD, s_in=1, Rn=0x7FFFFFFF, imm so=12'h001 -> res=0x80000000; NZCV=1001.
- ADC with C=1: imm so=12'h402 (2 ror 8 = 0x02000000), Rn=1 -> 0x02000002.
- LDR-style (MEM_r_en_in=1), Rn=0x100, so=12'h004 -> alu_res_out=0x104. Hold stall=1 for 3 cycles -> outputs unchanged. Assert rst mid-stall -> all registered outputs 0 at the next edge.
- b_in=1, pc_in=0x20, imm24=24'hFFFFFE -> branch_addr=0x18 same cycle. With FORWARDING_EN: sel_src_1=01, mem_fwd_val=7, MOV-free ADD Val2=1 -> res=8.
